// File: rtl/riscv_dmem_arbiter.sv
// Data-memory arbiter: shares one single-port dmem between the pipeline
// memory stage (core) and a debug/loader port (dbg). Core has fixed
// priority; a starvation counter forces a dbg grant after STARVE_MAX
// consecutive core grants that left dbg waiting.
module riscv_dmem_arbiter #(
  parameter int DMEM_ADDR_BIT = 12,
  parameter int LATENCY       = 1,
  parameter int STARVE_MAX    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_core_req,
  input  logic                     i_core_we,
  input  logic [31:0]              i_core_addr,
  input  logic [31:0]              i_core_wdata,
  input  logic [3:0]               i_core_be,
  output logic [31:0]              o_core_rdata,
  output logic                     o_core_ack,
  output logic                     o_core_stall,
  input  logic                     i_dbg_req,
  input  logic                     i_dbg_we,
  input  logic [31:0]              i_dbg_addr,
  input  logic [31:0]              i_dbg_wdata,
  input  logic [3:0]               i_dbg_be,
  output logic [31:0]              o_dbg_rdata,
  output logic                     o_dbg_ack,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [DMEM_ADDR_BIT-3:0] o_mem_addr,
  output logic [31:0]              o_mem_wdata,
  output logic [3:0]               o_mem_be,
  input  logic [31:0]              i_mem_rdata,
  output logic                     o_err,
  output logic                     o_owner,
  output logic                     o_busy
);
  localparam int         WA       = DMEM_ADDR_BIT - 2;
  localparam logic [2:0] LAT_LAST = 3'(LATENCY - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      wait_cnt;
  logic [3:0]      starve_cnt;
  logic            lat_we, lat_oor, lat_owner;
  logic [WA-1:0]   lat_waddr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;
  logic [31:0]     core_rdata, dbg_rdata;
  logic            dbg_starved, grant_core, grant_dbg, last_beat;
  logic            unused_addr_lsbs;

  // Byte-offset bits never reach the word-addressed memory.
  assign unused_addr_lsbs = ^{i_core_addr[1:0], i_dbg_addr[1:0]};

  assign dbg_starved = i_core_req & i_dbg_req & (starve_cnt == SMAX);
  assign grant_core  = (state == IDLE) & i_core_req & ~dbg_starved;
  assign grant_dbg   = (state == IDLE) & i_dbg_req & ~grant_core;
  assign last_beat   = (state == ACCESS) & (wait_cnt == LAT_LAST);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: IDLE -> ACCESS (LATENCY cycles) -> RESP (1 cycle) -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_core | grant_dbg) state_nxt = ACCESS;
      ACCESS:  if (last_beat) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait/starve counters and per-port read-data registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt   <= '0;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
      lat_owner  <= 1'b0;
      lat_waddr  <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      if (grant_core) begin
        lat_owner  <= 1'b0;
        lat_we     <= i_core_we;
        lat_oor    <= |i_core_addr[31:DMEM_ADDR_BIT];
        lat_waddr  <= i_core_addr[DMEM_ADDR_BIT-1:2];
        lat_wdata  <= i_core_wdata;
        lat_be     <= i_core_be;
        wait_cnt   <= '0;
        // Count only grants that made dbg wait; saturate at the limit.
        if (!i_dbg_req)          starve_cnt <= '0;
        else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
      end else if (grant_dbg) begin
        lat_owner  <= 1'b1;
        lat_we     <= i_dbg_we;
        lat_oor    <= |i_dbg_addr[31:DMEM_ADDR_BIT];
        lat_waddr  <= i_dbg_addr[DMEM_ADDR_BIT-1:2];
        lat_wdata  <= i_dbg_wdata;
        lat_be     <= i_dbg_be;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end else if (state == ACCESS && !last_beat) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      // Load on the final ACCESS edge so the value is visible alongside ack.
      if (last_beat) begin
        if (lat_owner) dbg_rdata  <= (lat_we | lat_oor) ? 32'h0 : i_mem_rdata;
        else           core_rdata <= (lat_we | lat_oor) ? 32'h0 : i_mem_rdata;
      end
    end
  end

  assign o_mem_en     = (state == ACCESS);
  assign o_mem_we     = o_mem_en & lat_we & ~lat_oor;
  assign o_mem_addr   = o_mem_en ? lat_waddr : '0;
  assign o_mem_wdata  = o_mem_en ? lat_wdata : '0;
  assign o_mem_be     = o_mem_en ? lat_be    : '0;
  assign o_core_ack   = (state == RESP) & ~lat_owner;
  assign o_dbg_ack    = (state == RESP) &  lat_owner;
  assign o_err        = (state == RESP) &  lat_oor;
  assign o_busy       = (state != IDLE);
  assign o_owner      = o_busy & lat_owner;
  assign o_core_stall = i_core_req & ~o_core_ack;
  assign o_core_rdata = core_rdata;
  assign o_dbg_rdata  = dbg_rdata;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: table of single transactions plus
// directed starvation and mid-access reset sequences; acks are checked
// against per-port expectation queues.
module tb_riscv_dmem_arbiter;
  localparam int AB  = 12;
  localparam int LAT = 3;
  localparam int SM  = 4;

  logic            clk, rst;
  logic            core_req, core_we, core_ack, core_stall;
  logic [31:0]     core_addr, core_wdata, core_rdata;
  logic [3:0]      core_be;
  logic            dbg_req, dbg_we, dbg_ack;
  logic [31:0]     dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]      dbg_be;
  logic            mem_en, mem_we, err, owner, busy;
  logic [AB-3:0]   mem_addr;
  logic [31:0]     mem_wdata, mem_rdata;
  logic [3:0]      mem_be;
  logic            mem_init;
  logic [31:0]     mem [0:1023];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        port;   // 0 core, 1 dbg
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t core_q[$];
  exp_t dbg_q[$];
  exp_t mon_e;
  vec_t tbl[12];

  riscv_dmem_arbiter #(.DMEM_ADDR_BIT(AB), .LATENCY(LAT), .STARVE_MAX(SM)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_be(core_be),
    .o_core_rdata(core_rdata), .o_core_ack(core_ack), .o_core_stall(core_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .i_dbg_be(dbg_be),
    .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_rdata(mem_rdata),
    .o_err(err), .o_owner(owner), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with byte enables, async read
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({mem_en, mem_we, core_ack, dbg_ack, err, owner, busy}), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_be"}, 32'(mem_be), 32'h0);
    chk({tag, "_core_rdata"}, core_rdata, 32'h0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'h0);
  endtask

  // Scoreboard: every ack pops the matching port's expectation
  always @(negedge clk) begin
    if (!rst && (core_ack || dbg_ack)) begin
      chk("single_ack", 32'(core_ack & dbg_ack), 32'h0);
      chk("busy_at_ack", 32'(busy), 32'h1);
      if (core_ack) begin
        if (core_q.size() == 0) chk("core_unexpected_ack", 32'h1, 32'h0);
        else begin
          mon_e = core_q.pop_front();
          chk("core_rdata", core_rdata, mon_e.rdata);
          chk("core_err", 32'(err), 32'(mon_e.err));
          chk("core_owner", 32'(owner), 32'h0);
        end
      end else begin
        if (dbg_q.size() == 0) chk("dbg_unexpected_ack", 32'h1, 32'h0);
        else begin
          mon_e = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata, mon_e.rdata);
          chk("dbg_err", 32'(err), 32'(mon_e.err));
          chk("dbg_owner", 32'(owner), 32'h1);
        end
      end
    end
  end

  task automatic run_txn(input vec_t v, output int lat, output int en_n,
                         output int we_n, output logic addr_ok);
    lat = 0; en_n = 0; we_n = 0; addr_ok = 1'b1;
    @(negedge clk);
    if (v.port) begin
      dbg_req = 1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata; dbg_be = v.be;
      dbg_q.push_back('{v.exp_rdata, v.exp_err});
    end else begin
      core_req = 1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata; core_be = v.be;
      core_q.push_back('{v.exp_rdata, v.exp_err});
    end
    #1 chk("stall_cycle0", 32'(core_stall), 32'(!v.port));
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        en_n++;
        if (mem_addr !== v.addr[AB-1:2]) addr_ok = 1'b0;
      end
      if (mem_we) we_n++;
      if (core_ack || dbg_ack) begin
        lat = k;
        chk("stall_at_ack", 32'(core_stall), 32'h0);
        break;
      end
    end
    @(negedge clk);
    core_req = 0; dbg_req = 0;
  endtask

  initial begin
    int   lat, en_n, we_n, n;
    logic addr_ok;
    int   ack_cyc[6];
    logic ack_own[6];

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_5555, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'h3, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         4'hF, 32'h0000_5678, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'hAAAA_5555, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hC, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0000_0FFE, 32'h0,         4'hF, 32'hCAFE_0000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 32'h0000_0000, 1'b1};

    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0;
    rst = 1; mem_init = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    rst = 0; mem_init = 0;

    // Single transactions, one at a time
    foreach (tbl[i]) begin
      run_txn(tbl[i], lat, en_n, we_n, addr_ok);
      chk($sformatf("t%0d_ack_latency", i), 32'(lat), 32'(LAT + 1));
      chk($sformatf("t%0d_mem_en_cycles", i), 32'(en_n), 32'(LAT));
      chk($sformatf("t%0d_mem_we_cycles", i), 32'(we_n),
          32'((tbl[i].we && !tbl[i].exp_err) ? LAT : 0));
      chk($sformatf("t%0d_mem_addr", i), 32'(addr_ok), 32'h1);
    end
    // Core rdata survives a later dbg ack
    chk("core_rdata_hold", core_rdata, 32'hCAFE_0000);

    // Starvation: both requests held; core reads 0x40, dbg reads 0x0
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 32'h40; core_be = 4'hF;
    dbg_req  = 1; dbg_we  = 0; dbg_addr  = 32'h0;  dbg_be  = 4'hF;
    for (int i = 0; i < 5; i++) core_q.push_back('{32'hDEAD_BEEF, 1'b0});
    dbg_q.push_back('{32'hAAAA_5555, 1'b0});
    n = 0;
    for (int k = 1; k <= 8 * (LAT + 2); k++) begin
      @(posedge clk); #1;
      if (core_ack || dbg_ack) begin
        ack_cyc[n] = k; ack_own[n] = dbg_ack; n++;
        if (n == 6) break;
      end
    end
    @(negedge clk);
    core_req = 0; dbg_req = 0;
    chk("starve_ack_count", 32'(n), 32'd6);
    if (n == 6) begin
      chk("starve_order", 32'({ack_own[0], ack_own[1], ack_own[2], ack_own[3], ack_own[4], ack_own[5]}),
          32'b000010);
      chk("both_req_first_ack", 32'(ack_cyc[0]), 32'(LAT + 1));
      chk("b2b_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'(LAT + 2));
      chk("dbg_after_core_spacing", 32'(ack_cyc[4] - ack_cyc[3]), 32'(LAT + 2));
    end

    // Reset in the middle of ACCESS, core request held throughout
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 32'h40; core_be = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_mem_en", 32'(mem_en), 32'h1);
    rst = 1;
    #1 chk_quiet("mid_reset");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("reset_no_ack", 32'({core_ack, dbg_ack, mem_en}), 32'h0);
    end
    core_q.push_back('{32'hDEAD_BEEF, 1'b0});
    @(negedge clk);
    rst = 0;
    lat = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (core_ack) begin lat = k; break; end
    end
    chk("restart_latency", 32'(lat), 32'(LAT + 1));
    @(negedge clk);
    core_req = 0;
    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(core_q.size() + dbg_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
